// File: rtl/fmap_stream_reader.sv
// Feature-map read-out: triggers the upstream layer, sweeps its read port and streams the
// returned nibbles out over valid/ready. Define FMAP_PACK8_EN to pack 8 nibbles per beat.
module fmap_stream_reader #(
  parameter int unsigned TOTAL  = 2048,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        up_start,
  input  logic        up_done,
  output logic [31:0] up_read_addr,
  input  logic [3:0]  up_read_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
);
`ifdef FMAP_PACK8_EN
  localparam int unsigned FW  = 32;
  localparam int unsigned NPB = 8;
`else
  localparam int unsigned FW  = 4;
  localparam int unsigned NPB = 1;
`endif
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CAP = DEPTH * NPB;

  typedef enum logic [1:0] {IDLE, WAIT_UP, STREAM, DRAIN} state_t;

  state_t          state, state_n;
  logic            busy_n, done_n, up_start_n, issue_c;
  logic [31:0]     iss, ret_cnt;
  logic [RD_LAT:0] pipe;
  logic [FW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] last_mem;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ret_c, fifo_wr_c, fifo_rd_c, drained_c;
  logic [FW-1:0]   wdata_c;
  logic [31:0]     used_c;

`ifdef FMAP_PACK8_EN
  logic [2:0]  pack_cnt;
  logic [27:0] pack_q;

  if (TOTAL % 8 != 0) begin : g_total_chk
    $error("fmap_stream_reader: TOTAL must be a multiple of 8 when packing");
  end

  // Credits are counted in nibbles: packer slots plus whole FIFO words.
  assign used_c    = 32'(count) * NPB + 32'($countones(pipe)) + 32'(pack_cnt);
  assign fifo_wr_c = ret_c && (pack_cnt == 3'd7);
  assign wdata_c   = {pack_q, up_read_data};
  assign drained_c = (pipe == '0) && (count == '0) && (pack_cnt == 3'd0);
`else
  assign used_c    = 32'(count) + 32'($countones(pipe));
  assign fifo_wr_c = ret_c;
  assign wdata_c   = up_read_data;
  assign drained_c = (pipe == '0) && (count == '0);
`endif

  // The tag sits in the last pipe stage during the cycle its read data is valid.
  assign ret_c     = pipe[RD_LAT];
  assign fifo_rd_c = m_valid && m_ready;

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? 32'(mem[rd_ptr]) : 32'd0;
  assign m_last  = m_valid && last_mem[rd_ptr];

  always_comb begin
    state_n    = state;
    busy_n     = (state != IDLE);
    done_n     = 1'b0;
    up_start_n = 1'b0;
    issue_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = WAIT_UP;
          busy_n     = 1'b1;
          up_start_n = 1'b1;
        end
      end
      WAIT_UP: begin
        if (up_done) state_n = STREAM;
      end
      STREAM: begin
        if (iss == 32'(TOTAL)) state_n = DRAIN;
        else if (used_c < CAP) issue_c = 1'b1;
      end
      DRAIN: begin
        if (drained_c) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      up_start <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      done     <= done_n;
      up_start <= up_start_n;
    end
  end

  // Issue counter, read-tag pipe and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iss          <= '0;
      ret_cnt      <= '0;
      pipe         <= '0;
      up_read_addr <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_mem     <= '0;
`ifdef FMAP_PACK8_EN
      pack_cnt     <= '0;
      pack_q       <= '0;
`endif
    end else begin
      pipe <= {pipe[RD_LAT-1:0], issue_c};
      if (state == WAIT_UP && up_done) begin
        iss     <= '0;
        ret_cnt <= '0;
      end
      if (issue_c) begin
        up_read_addr <= iss;
        iss          <= iss + 32'd1;
      end
      if (ret_c) ret_cnt <= ret_cnt + 32'd1;
`ifdef FMAP_PACK8_EN
      if (ret_c) begin
        pack_q   <= {pack_q[23:0], up_read_data};
        pack_cnt <= pack_cnt + 3'd1;
      end
`endif
      if (fifo_wr_c) begin
        last_mem[wr_ptr] <= (ret_cnt == 32'(TOTAL - 1));
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (fifo_rd_c) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(fifo_wr_c) - CW'(fifo_rd_c);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr_c) mem[wr_ptr] <= wdata_c;
  end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Bench for fmap_stream_reader: randomized backpressure, stray start/up_done, mid-transfer
// reset and a single-beat instance, checked by a queue-based scoreboard.
module tb_fmap_stream_reader;
`ifdef FMAP_PACK8_EN
  localparam int EPB = 8;
`else
  localparam int EPB = 1;
`endif
  localparam int TOTAL   = 2048;
  localparam int RD_LAT  = 3;
  localparam int DEPTH   = 4;
  localparam int BEATS   = TOTAL / EPB;
  localparam int RST_AT  = BEATS * 700 / 2048;
  localparam int TOTAL_S = EPB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        start = 1'b0, busy, done, up_start, up_done, m_valid, m_ready = 1'b0, m_last;
  logic [31:0] up_read_addr, m_data;
  logic [3:0]  up_read_data;
  logic        stray_done = 1'b0;
  logic [3:0]  key = 4'd0;

  // single-beat instance
  logic        start_s = 1'b0, busy_s, done_s, up_start_s, up_done_s, m_valid_s, m_ready_s = 1'b0, m_last_s;
  logic [31:0] addr_s, m_data_s;
  logic [3:0]  data_s;
  logic [3:0]  key_s = 4'd0;

  fmap_stream_reader #(.TOTAL(TOTAL), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .up_start(up_start), .up_done(up_done), .up_read_addr(up_read_addr),
    .up_read_data(up_read_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last));

  fmap_stream_reader #(.TOTAL(TOTAL_S), .RD_LAT(1), .DEPTH(2)) u_one (
    .clk(clk), .resetn(resetn), .start(start_s), .busy(busy_s), .done(done_s),
    .up_start(up_start_s), .up_done(up_done_s), .up_read_addr(addr_s),
    .up_read_data(data_s), .m_valid(m_valid_s), .m_ready(m_ready_s),
    .m_data(m_data_s), .m_last(m_last_s));

  int n_cmp = 0, n_bad = 0;
  int n_upstart = 0, n_done = 0, exp_starts = 0, exp_dones = 0;
  int beat_cnt = 0;
  int ready_pct = 100;
  logic [32:0] exp_q[$];

  function automatic logic [3:0] elem(input logic [31:0] a, input logic [3:0] k);
    return a[3:0] ^ a[7:4] ^ k;
  endfunction

  // Expected beat b: EPB consecutive elements, first element in the top nibble.
  function automatic logic [31:0] beat(input int b, input logic [3:0] k);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < EPB; j++) w = (w << 4) | 32'(elem(32'(b * EPB + j), k));
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream layer models: fixed read latency and a randomly delayed done pulse.
  logic [3:0] rd_pipe [RD_LAT];
  logic [3:0] rd_s;
  int up_cd = 0, up_cd_s = 0;
  always @(posedge clk) begin
    rd_pipe[0] <= elem(up_read_addr, key);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    rd_s <= elem(addr_s, key_s);
    if (!resetn) begin
      up_cd   <= 0;
      up_cd_s <= 0;
    end else begin
      if (up_start) up_cd <= $urandom_range(1, 6);
      else if (up_cd > 0) up_cd <= up_cd - 1;
      if (up_start_s) up_cd_s <= $urandom_range(1, 6);
      else if (up_cd_s > 0) up_cd_s <= up_cd_s - 1;
    end
  end
  assign up_read_data = rd_pipe[RD_LAT-1];
  assign up_done      = (up_cd == 1) || stray_done;
  assign data_s       = rd_s;
  assign up_done_s    = (up_cd_s == 1);

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks stalls and done timing.
  initial begin : monitor
    logic [32:0] e;
    logic [31:0] pd;
    logic        pl;
    bit          ps, pdone;
    int          since_last;
    ps = 0; pdone = 0; since_last = 1000; pd = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ps = 0; pdone = 0; since_last = 1000;
      end else begin
        if (up_start) n_upstart++;
        if (ps) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, pl, pd});
        if (pdone) check("busy_after_done", busy, 0);
        if (done) begin
          n_done++;
          check("done_q_empty", exp_q.size(), 0);
          check("done_latency", since_last, 1);
          check("busy_at_done", busy, 1);
        end
        pdone = done;
        if (since_last < 1000) since_last++;
        if (m_valid && m_ready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat", {m_last, m_data}, e);
          end
          beat_cnt++;
          if (m_last) since_last = 0;
        end
        ps = m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_main(input bit accept);
    if (accept) begin
      key = 4'($urandom);
      for (int b = 0; b < BEATS; b++) exp_q.push_back({(b == BEATS - 1), beat(b, key)});
      exp_starts++;
      exp_dones++;
      beat_cnt = 0;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int bound);
    int c = 0;
    while (beat_cnt < n && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("reach_beat", beat_cnt >= n, 1);
    cyc();
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    bit got = 0;
    while (!got && c < bound) begin
      @(negedge clk);
      got = done;
      c++;
    end
    check("done_seen", got, 1);
    cyc();
    cyc();
  endtask

  initial begin : main
    logic [32:0] d0;
    int c;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_outputs", {busy, done, up_start, m_valid, m_last}, 0);
    check("rst_addr", up_read_addr, 0);
    check("rst_data", m_data, 0);
    check("rst_small", {busy_s, done_s, up_start_s, m_valid_s}, 0);
    cyc();
    resetn = 1'b1;
    repeat (2) cyc();

    // full transfer, no backpressure, with starts ignored in WAIT_UP and STREAM
    ready_pct = 100;
    start_main(1);
    start_main(0);
    wait_beats(BEATS / 20, 5000);
    start_main(0);
    wait_done(20000);

    // up_done while idle must not trigger anything
    stray_done = 1'b1;
    cyc();
    stray_done = 1'b0;
    repeat (10) cyc();
    @(negedge clk);
    check("idle_after_stray", {busy, m_valid}, 0);
    check("up_start_count_a", n_upstart, exp_starts);
    cyc();

    // heavy backpressure
    ready_pct = 30;
    start_main(1);
    wait_beats(BEATS / 2, 20000);
    start_main(0);
    wait_done(30000);

    // reset in the middle of a transfer
    ready_pct = 60;
    start_main(1);
    wait_beats(RST_AT, 20000);
    resetn = 1'b0;
    exp_q.delete();
    exp_dones--;
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset", {m_valid, busy, done}, 0);
    cyc();
    repeat (3) cyc();

    // fresh transfer after reset restarts from address 0
    ready_pct = 100;
    start_main(1);
    wait_done(20000);

    // single-beat instance: beat held under backpressure, done only after acceptance
    key_s = 4'($urandom);
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    c = 0;
    while (!m_valid_s && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("s_valid", m_valid_s, 1);
    d0 = {m_last_s, m_data_s};
    check("s_beat", d0, {1'b1, beat(0, key_s)});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("s_hold", {m_valid_s, m_last_s, m_data_s, done_s}, {1'b1, d0, 1'b0});
    end
    @(posedge clk);
    #1;
    m_ready_s = 1'b1;
    @(negedge clk);
    check("s_no_early_done", done_s, 0);
    @(posedge clk);
    #1;
    m_ready_s = 1'b0;
    @(negedge clk);
    check("s_after_accept", {m_valid_s, done_s, busy_s}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("s_done", {done_s, busy_s}, {1'b1, 1'b1});
    @(negedge clk);
    check("s_idle", {done_s, busy_s, m_valid_s}, 0);

    check("up_start_count", n_upstart, exp_starts);
    check("done_count", n_done, exp_dones);
    check("q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
